uart_rx: RTL
============

Name: uart_rx

Overview:
- Serial receiver; sits directly downstream of the UART transmitter and consumes its TX_OUT line.
- Recovers frames with the same format the transmitter produces: start bit (0), 8 data bits LSB first, optional parity bit, stop bit (1).
- Reconstructs P_DATA, raises a one-cycle DATA_VALID strobe per good frame, and flags parity and stop errors.
- Oversamples each bit PRESCALE times and takes a 3-sample majority vote at mid-bit.

Parameters:
- PRESCALE, 8, clocks per serial bit. Must be even and at least 4.
- DATA_W, 8, data bits per frame. Fixed at 8 for this revision.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous reset, active-high.
- RX_IN  input  1  serial line; idles high.
- PAR_EN  input  1  1 means the frame carries a parity bit.
- PAR_TYP  input  1  parity select. Expected parity = ~^data when 0, ^data when 1 (identical rule to the transmitter).
- P_DATA  output  8  last correctly received byte.
- DATA_VALID  output  1  one-cycle strobe; P_DATA is new.
- PAR_ERR  output  1  one-cycle strobe; parity mismatch.
- STP_ERR  output  1  one-cycle strobe; stop bit sampled 0.
- Busy  output  1  high while a frame is being received.

Behaviour:
- Reset values:
  - P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0, Busy=0.
  - state=IDLE, edge_cnt=0, bit_cnt=0, armed=0.
- Counters:
  - edge_cnt counts 0..PRESCALE-1 within each bit, then wraps to 0 and the bit ends.
  - Sample ticks are M-1, M and M+1, where M=PRESCALE/2.
  - The bit value is the majority of the three samples.
- armed: set on the first cycle with RX_IN=1 while in IDLE. No start detection is allowed while armed=0. This prevents false frames after reset released mid-frame or while the line is held low.
- IDLE:
  - Busy=0.
  - Start detection: RX_IN==0 and armed. The detection cycle is edge 0 of the start bit.
  - On detection: latch PAR_EN and PAR_TYP, go to START, set edge_cnt=1.
- START:
  - Busy=1.
  - At edge PRESCALE-1: if the majority is 1, the start was a glitch; go to IDLE with no strobes.
  - Otherwise go to DATA with bit_cnt=0.
- DATA:
  - At each bit end, shift the majority into position bit_cnt (LSB first) and increment bit_cnt.
  - After bit 7, go to PARITY if latched PAR_EN=1, else go to STOP.
- PARITY:
  - At bit end, compare the majority against the expected parity of the shifted byte.
  - Record mismatch in par_bad, then go to STOP.
- STOP: evaluated at edge M+1, not at bit end, so the next start edge is caught. At that edge, go to IDLE with armed=1. On the following cycle:
  - Stop majority 1 and !par_bad: DATA_VALID=1 and P_DATA=the received byte.
  - par_bad: PAR_ERR=1; P_DATA holds its old value.
  - Stop majority 0: STP_ERR=1; P_DATA holds. PAR_ERR and STP_ERR may both pulse in the same cycle.
  - All strobes last exactly one cycle.
- Latency, PRESCALE=8, detection at cycle 0:
  - No parity: strobes at cycle 78 (9 bits × 8 + 5 + 1).
  - With parity: strobes at cycle 86.
  - Busy rises at cycle 1 and falls on the strobe cycle.
- Back-to-back frames: a start edge one cycle after the stop evaluation must be detected.
- Mid-frame changes:
  - PAR_EN and PAR_TYP changes mid-frame are ignored; the latched values apply.
  - Asserting reset at any point returns every output and register to its reset value immediately. No strobe is issued for the aborted frame.

Decomposition:
- Shared package uart_pkg holds:
  - state enum {IDLE, START, DATA, PARITY, STOP}, the same encoding the transmitter uses;
  - DATA_W;
  - a parity function par_calc(data, typ).
- One sub-module: uart_rx_sampler. It owns edge_cnt, the three-sample capture and the majority vote, and outputs bit_val and bit_end/mid_done pulses.
- The FSM, shifter and error logic stay in uart_rx.

Test Plan:
- PRESCALE=8, PAR_EN=0, send 0xA5 → DATA_VALID at cycle 78 after detection, P_DATA=0xA5, PAR_ERR=STP_ERR=0.
- PAR_EN=1, PAR_TYP=0, send 0x3C with parity bit ~^0x3C=1 → DATA_VALID, P_DATA=0x3C. Repeat with the parity bit inverted → PAR_ERR pulse only, P_DATA stays 0x3C from the prior frame.
- Line low for 3 clocks, then high → no strobe, Busy returns to 0 at the end of the start bit, state IDLE.
- Send 0x81 with stop bit forced 0 → STP_ERR pulse, no DATA_VALID.
- Single-cycle glitch at tick M on every data bit of 0x55 → majority vote rejects it, P_DATA=0x55.
- Two frames 0x12 and 0xEF back-to-back (second start edge one cycle after the first stop evaluation) → two DATA_VALID pulses with the correct bytes. Assert reset mid-second-frame with RX_IN held low after release → all outputs 0, no strobe until RX_IN returns high.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared frame constants, FSM encoding and parity rule for the UART blocks.
package uart_pkg;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    function automatic logic par_calc(input logic [DATA_W-1:0] data, input logic typ);
        return typ ? ^data : ~^data;
    endfunction
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge counter with three mid-bit samples and majority vote.
module uart_rx_sampler #(
    parameter int PRESCALE = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    input  logic start,
    input  logic run,
    output logic bit_val,
    output logic bit_end,
    output logic mid_done
);
    localparam int W = $clog2(PRESCALE);
    localparam logic [W-1:0] M = W'(PRESCALE / 2);
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] edge_cnt;
    logic [2:0]   smp;
    logic         third;

    assign bit_end  = edge_cnt == LAST;
    assign mid_done = edge_cnt == M + 1'b1;
    // The stop bit is judged on its last sample tick, so the live line stands in for the third sample.
    assign third    = mid_done ? rx : smp[2];
    assign bit_val  = (smp[0] & smp[1]) | (smp[0] & third) | (smp[1] & third);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_cnt <= '0;
            smp      <= '0;
        end else begin
            edge_cnt <= start ? W'(1) : (run && !bit_end) ? edge_cnt + 1'b1 : '0;
            if (edge_cnt == M - 1'b1) smp[0] <= rx;
            if (edge_cnt == M) smp[1] <= rx;
            if (mid_done) smp[2] <= rx;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver; frame FSM, LSB-first shifter and parity/stop error strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int PRESCALE = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RX_IN,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    output logic [DATA_W-1:0] P_DATA,
    output logic              DATA_VALID,
    output logic              PAR_ERR,
    output logic              STP_ERR,
    output logic              Busy
);
    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_t            state;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shift;
    logic              armed, par_bad, en_l, typ_l;
    logic              bit_val, bit_end, mid_done, start, run;

    // armed blocks start detection until the line has been seen idle high.
    assign start = state == IDLE && !RX_IN && armed;
    assign run   = state != IDLE && !(state == STOP && mid_done);

    uart_rx_sampler #(.PRESCALE(PRESCALE)) u_sampler (
        .clk      (clk),
        .reset    (reset),
        .rx       (RX_IN),
        .start    (start),
        .run      (run),
        .bit_val  (bit_val),
        .bit_end  (bit_end),
        .mid_done (mid_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            armed      <= 1'b0;
            par_bad    <= 1'b0;
            en_l       <= 1'b0;
            typ_l      <= 1'b0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
            case (state)
                IDLE: begin
                    if (RX_IN) armed <= 1'b1;
                    if (start) begin
                        state   <= START;
                        en_l    <= PAR_EN;
                        typ_l   <= PAR_TYP;
                        par_bad <= 1'b0;
                        Busy    <= 1'b1;
                    end
                end
                START: if (bit_end) begin
                    state   <= bit_val ? IDLE : DATA;
                    Busy    <= !bit_val;
                    bit_cnt <= '0;
                end
                DATA: if (bit_end) begin
                    shift[bit_cnt] <= bit_val;
                    bit_cnt        <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) state <= en_l ? PARITY : STOP;
                end
                PARITY: if (bit_end) begin
                    par_bad <= bit_val != par_calc(shift, typ_l);
                    state   <= STOP;
                end
                STOP: if (mid_done) begin
                    state      <= IDLE;
                    armed      <= 1'b1;
                    Busy       <= 1'b0;
                    DATA_VALID <= bit_val && !par_bad;
                    PAR_ERR    <= par_bad;
                    STP_ERR    <= !bit_val;
                    if (bit_val && !par_bad) P_DATA <= shift;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
